regfile_dbg: RTL and testbench

REGFILE_DBG -- requirements
Module: regfile_dbg

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_dbg_if.sv | 33 +++
 rtl/regfile_dump_fsm.sv | 81 ++++++++
 rtl/regfile_dbg.sv | 66 ++++++
 tb/tb_regfile_dbg.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and dump-engine state type for the debug register file.
package regfile_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } dump_state_e;
endpackage

// File: rtl/regfile_dbg_if.sv
// Register-file access bus: write port, packed read ports and the dump stream.
interface regfile_dbg_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF
);
  localparam int AW = $clog2(NREGS);

  logic                regWrite;
  logic [AW-1:0]       writeReg;
  logic [XLEN-1:0]     writeData;
  logic [NRD*AW-1:0]   readReg;
  logic [NRD*XLEN-1:0] readData;
  logic                dump_start;
  logic                dump_valid;
  logic                dump_ready;
  logic [AW-1:0]       dump_index;
  logic [XLEN-1:0]     dump_data;
  logic                dump_busy;
  logic                dump_done;

  modport master (
    output regWrite, writeReg, writeData, readReg, dump_start, dump_ready,
    input  readData, dump_valid, dump_index, dump_data, dump_busy, dump_done
  );

  modport slave (
    input  regWrite, writeReg, writeData, readReg, dump_start, dump_ready,
    output readData, dump_valid, dump_index, dump_data, dump_busy, dump_done
  );
endinterface

// File: rtl/regfile_dump_fsm.sv
// Streams every register out one beat per accepted handshake; data for the next
// beat is captured at the accepting edge from cap_dat_i (selected by cap_idx_o).
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start_i,
  input  logic            ready_i,
  input  logic [XLEN-1:0] cap_dat_i,
  output logic [AW-1:0]   cap_idx_o,
  output logic            valid_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [AW-1:0]   index_o,
  output logic [XLEN-1:0] data_o
);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  dump_state_e     state_q;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;
  logic [AW-1:0]   index_q;
  logic [XLEN-1:0] data_q;

  assign cap_idx_o = (state_q == SCAN) ? index_q + AW'(1) : '0;

  // valid is always high in SCAN, so ready alone marks an accepted beat there
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= SCAN;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            index_q <= '0;
            data_q  <= cap_dat_i;
          end
        end
        SCAN: begin
          if (ready_i) begin
            if (index_q == LAST_IDX) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              index_q <= cap_idx_o;
              data_q  <= cap_dat_i;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign index_o = index_q;
  assign data_o  = data_q;
endmodule

// File: rtl/regfile_dbg.sv
// Register file with NRD combinational read ports and a register dump stream.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_dbg
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF
) (
  input  logic         clock,
  input  logic         reset,
  regfile_dbg_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]     regs_q [NREGS];
  logic [NRD*XLEN-1:0] rd_dat;
  logic [AW-1:0]       cap_idx;
  logic [XLEN-1:0]     cap_dat;

  // Entry 0 is cleared by reset and never written, so it reads as zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (bus.regWrite && bus.writeReg != '0) begin
      regs_q[bus.writeReg] <= bus.writeData;
    end
  end

  always_comb begin
    rd_dat = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_dat[k*XLEN +: XLEN] = regs_q[bus.readReg[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      if (bus.regWrite && bus.writeReg != '0 && bus.readReg[k*AW +: AW] == bus.writeReg)
        rd_dat[k*XLEN +: XLEN] = bus.writeData;
`endif
    end
  end

  assign bus.readData = rd_dat;

  // Capture must include a write landing on the same edge as the capture.
  always_comb begin
    cap_dat = regs_q[cap_idx];
    if (bus.regWrite && bus.writeReg != '0 && bus.writeReg == cap_idx)
      cap_dat = bus.writeData;
  end

  regfile_dump_fsm #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_dump (
    .clock     (clock),
    .reset     (reset),
    .start_i   (bus.dump_start),
    .ready_i   (bus.dump_ready),
    .cap_dat_i (cap_dat),
    .cap_idx_o (cap_idx),
    .valid_o   (bus.dump_valid),
    .busy_o    (bus.dump_busy),
    .done_o    (bus.dump_done),
    .index_o   (bus.dump_index),
    .data_o    (bus.dump_data)
  );
endmodule

// File: tb/tb_regfile_dbg.sv
// Bench for regfile_dbg: vector table, randomized traffic against a reference
// model, and dump-stream corner cases. Honours REGFILE_BYPASS_EN when defined.
module tb_regfile_dbg;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic clock;
  logic reset;

  regfile_dbg_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  regfile_dbg #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: register contents plus the dump stream's expected beat.
  logic [XLEN-1:0] mdl [NREGS];
  bit              m_active;
  bit              m_done;
  int              m_idx;
  logic [XLEN-1:0] m_data;

  typedef struct {
    logic            we;
    logic [AW-1:0]   wr;
    logic [XLEN-1:0] wd;
    logic [AW-1:0]   r0;
    logic [AW-1:0]   r1;
    logic [XLEN-1:0] e0;
    logic [XLEN-1:0] e1;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    m_active = 1'b0;
    m_done   = 1'b0;
    m_idx    = 0;
    m_data   = '0;
  endtask

  task automatic check_model();
    for (int k = 0; k < NRD; k++) begin
      int              idx;
      logic [XLEN-1:0] e;
      idx = int'(bus.readReg[k*AW +: AW]);
      e   = (idx == 0) ? '0 : mdl[idx];
`ifdef REGFILE_BYPASS_EN
      if (bus.regWrite && bus.writeReg != 0 && idx == int'(bus.writeReg)) e = bus.writeData;
`endif
      chk($sformatf("rd%0d_model", k), bus.readData[k*XLEN +: XLEN], e);
    end
    chk("dump_valid", bus.dump_valid, m_active);
    chk("dump_busy", bus.dump_busy, m_active);
    chk("dump_done", bus.dump_done, m_done);
    if (m_active) begin
      chk("dump_index", bus.dump_index, m_idx);
      chk("dump_data", bus.dump_data, m_data);
    end
  endtask

  // Applies the rules for one rising edge: write first, then any capture.
  task automatic update_model();
    bit nd;
    nd = 1'b0;
    if (reset) begin
      reset_model();
      return;
    end
    if (bus.regWrite && bus.writeReg != 0) mdl[bus.writeReg] = bus.writeData;
    if (m_active && bus.dump_ready) begin
      if (m_idx == NREGS - 1) begin
        m_active = 1'b0;
        nd       = 1'b1;
      end else begin
        m_idx++;
        m_data = mdl[m_idx];
      end
    end else if (!m_active && !m_done && bus.dump_start) begin
      m_active = 1'b1;
      m_idx    = 0;
      m_data   = '0;
    end
    m_done = nd;
  endtask

  task automatic tick();
    @(posedge clock);
    update_model();
    #1;
  endtask

  task automatic cycle();
    @(negedge clock);
    check_model();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int beats, dones, stall;
    bit stalled;
    logic [XLEN-1:0] exp_byp;

    reset          = 1'b1;
    bus.regWrite   = 1'b0;
    bus.writeReg   = '0;
    bus.writeData  = '0;
    bus.readReg    = '0;
    bus.dump_start = 1'b0;
    bus.dump_ready = 1'b0;
    reset_model();

    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1, 5'd2,  32'h0,        32'h0};
    tbl[1] = '{1'b1, 5'd0,  32'h00000001, 5'd0, 5'd5,  32'h0,        32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd3,  32'hCAFEF00D, 5'd0, 5'd5,  32'h0,        32'hDEADBEEF};
    tbl[3] = '{1'b0, 5'd3,  32'h11111111, 5'd3, 5'd5,  32'hCAFEF00D, 32'hDEADBEEF};
    tbl[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd3, 5'd3,  32'hCAFEF00D, 32'hCAFEF00D};
    tbl[5] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd0, 32'hA5A5A5A5, 32'h0};

    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", bus.dump_valid, 1'b0);
    chk("rst_busy", bus.dump_busy, 1'b0);
    chk("rst_done", bus.dump_done, 1'b0);
    chk("rst_index", bus.dump_index, 5'd0);
    chk("rst_data", bus.dump_data, 32'h0);
    chk("rst_read", bus.readData, 64'h0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      bus.regWrite  = tbl[i].we;
      bus.writeReg  = tbl[i].wr;
      bus.writeData = tbl[i].wd;
      bus.readReg   = {tbl[i].r1, tbl[i].r0};
      @(negedge clock);
      chk($sformatf("vec%0d_rd0", i), bus.readData[31:0], tbl[i].e0);
      chk($sformatf("vec%0d_rd1", i), bus.readData[63:32], tbl[i].e1);
      check_model();
      tick();
    end

    // Same-cycle read of the register being written
    bus.regWrite  = 1'b1;
    bus.writeReg  = 5'd7;
    bus.writeData = 32'h12345678;
    bus.readReg   = {5'd5, 5'd7};
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'h12345678;
`else
    exp_byp = 32'h0;
`endif
    @(negedge clock);
    chk("bypass_rd0", bus.readData[31:0], exp_byp);
    check_model();
    tick();
    bus.regWrite = 1'b0;
    @(negedge clock);
    chk("after_write_rd0", bus.readData[31:0], 32'h12345678);
    check_model();
    tick();

    for (int c = 0; c < 200; c++) begin
      bus.regWrite  = 1'($urandom_range(0, 1));
      bus.writeReg  = AW'($urandom_range(0, NREGS - 1));
      bus.writeData = $urandom;
      bus.readReg   = (NRD*AW)'($urandom);
      if ($urandom_range(0, 3) == 0) bus.readReg[AW-1:0] = bus.writeReg;
      cycle();
    end

    // Full dump with ready held high; extra starts land in SCAN and DONE
    for (int i = 0; i < NREGS; i++) begin
      bus.regWrite  = 1'b1;
      bus.writeReg  = AW'(i);
      bus.writeData = 32'(i * 16);
      bus.readReg   = (NRD*AW)'($urandom);
      cycle();
    end
    bus.regWrite   = 1'b0;
    bus.dump_ready = 1'b1;
    bus.dump_start = 1'b1;
    cycle();
    beats = 0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      bus.dump_start = (c == 15 || c == 32);
      @(negedge clock);
      check_model();
      if (bus.dump_valid && bus.dump_ready) begin
        chk("seq_index", bus.dump_index, beats);
        chk("seq_data", bus.dump_data, beats * 16);
        beats++;
      end
      if (bus.dump_done) dones++;
      tick();
    end
    bus.dump_start = 1'b0;
    chk("beat_count", beats, 32);
    chk("done_pulses", dones, 1);
    chk("busy_after", bus.dump_busy, 1'b0);

    // Stall at index 4 while rewriting it; write x7 on the edge that captures it
    bus.readReg    = '0;
    bus.dump_start = 1'b1;
    cycle();
    bus.dump_start = 1'b0;
    stall = 0;
    for (int c = 0; c < 45; c++) begin
      stalled        = m_active && m_idx == 4 && stall < 3;
      bus.dump_ready = !stalled;
      bus.regWrite   = 1'b0;
      if (stalled && stall == 0) begin
        bus.regWrite  = 1'b1;
        bus.writeReg  = 5'd4;
        bus.writeData = 32'hAAAA;
      end
      if (m_active && m_idx == 6) begin
        bus.regWrite  = 1'b1;
        bus.writeReg  = 5'd7;
        bus.writeData = 32'h7777;
      end
      if (stalled) stall++;
      @(negedge clock);
      check_model();
      if (stalled) begin
        chk("stall_index", bus.dump_index, 5'd4);
        chk("stall_data", bus.dump_data, 32'h40);
      end
      if (m_active && m_idx == 7) chk("edge_capture", bus.dump_data, 32'h7777);
      tick();
    end
    chk("stall_cycles", stall, 3);
    bus.regWrite   = 1'b0;
    bus.dump_ready = 1'b1;
    bus.readReg    = {5'd7, 5'd4};
    @(negedge clock);
    chk("x4_after", bus.readData[31:0], 32'hAAAA);
    chk("x7_after", bus.readData[63:32], 32'h7777);
    check_model();
    tick();

    // Reset in the middle of a dump, with random writes running
    bus.dump_start = 1'b1;
    cycle();
    bus.dump_start = 1'b0;
    for (int c = 0; c < 40 && !(m_active && m_idx == 10); c++) begin
      bus.regWrite  = 1'($urandom_range(0, 1));
      bus.writeReg  = AW'($urandom_range(0, NREGS - 1));
      bus.writeData = $urandom;
      bus.readReg   = (NRD*AW)'($urandom);
      cycle();
    end
    chk("beat10_index", bus.dump_index, 5'd10);
    reset        = 1'b1;
    bus.regWrite = 1'b0;
    bus.readReg  = {5'd9, 5'd3};
    #1;
    reset_model();
    chk("mid_rst_valid", bus.dump_valid, 1'b0);
    chk("mid_rst_busy", bus.dump_busy, 1'b0);
    chk("mid_rst_done", bus.dump_done, 1'b0);
    chk("mid_rst_index", bus.dump_index, 5'd0);
    chk("mid_rst_data", bus.dump_data, 32'h0);
    chk("mid_rst_read", bus.readData, 64'h0);
    tick();
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check_model();
      if (bus.dump_done) dones++;
      tick();
    end
    chk("no_done_after_rst", dones, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
